mul_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. Sits beside the ALU in the EX stage and sequences mult/multu/div/divu through a fixed-latency busy window. Also executes mthi/mtlo and exposes HI/LO for mfhi/mflo. Generates the busy/stall indication the hazard unit uses to hold md-class instructions in D, and honours the exception flush so a cancelled instruction never starts.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_compute.sv | 67 ++++++
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state type.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_compute.sv
// Combinational datapath: 64-bit products and truncating quotient/remainder,
// packed as {hi, lo}, plus a divide-by-zero flag.
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [63:0] res,
    output logic        div_zero
);

    logic        a_neg_s;
    logic        b_neg_s;
    logic        b_zero_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_div_s;
    logic [31:0] bu_div_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;

    assign a_neg_s  = src_a[31];
    assign b_neg_s  = src_b[31];
    assign b_zero_s = (src_b == 32'd0);

    // Signed division works on magnitudes; 0x80000000 is its own magnitude.
    assign a_mag_s  = a_neg_s ? (32'd0 - src_a) : src_a;
    assign b_mag_s  = b_neg_s ? (32'd0 - src_b) : src_b;
    assign b_div_s  = b_zero_s ? 32'd1 : b_mag_s;
    assign bu_div_s = b_zero_s ? 32'd1 : src_b;

    assign q_mag_s = a_mag_s / b_div_s;
    assign r_mag_s = a_mag_s % b_div_s;
    assign q_s     = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    assign r_s     = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

    assign prod_signed_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_unsigned_s = {32'd0, src_a} * {32'd0, src_b};

    // Select the result for the requested operation.
    always_comb begin
        res      = 64'd0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT:  res = prod_signed_s;
            MD_MULTU: res = prod_unsigned_s;
            MD_DIV: begin
                res      = {r_s, q_s};
                div_zero = b_zero_s;
            end
            MD_DIVU: begin
                res      = {src_a % bu_div_s, src_a / bu_div_s};
                div_zero = b_zero_s;
            end
            default: begin
                res      = 64'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: sequences the
// fixed-latency busy window, commits results and raises the stall request.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             busy_r, busy_n;
    logic [63:0]      res_r, res_n;
    logic             dz_r, dz_n;
    logic [31:0]      hi_r, hi_n;
    logic [31:0]      lo_r, lo_n;
    logic [63:0]      res_s;
    logic             dz_s;
    logic             issue_s;

    md_compute u_compute (
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .res      (res_s),
        .div_zero (dz_s)
    );

    assign issue_s   = start & ~flush & (state_r == MD_IDLE);
    assign stall_req = busy_r | (start & ~flush & (md_op >= MD_MULT) & (md_op <= MD_DIVU));
    assign busy      = busy_r;
    assign hi        = hi_r;
    assign lo        = lo_r;

    // Next-state, counter, result buffer and HI/LO update.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        busy_n  = busy_r;
        res_n   = res_r;
        dz_n    = dz_r;
        hi_n    = hi_r;
        lo_n    = lo_r;
        case (state_r)
            MD_IDLE: begin
                if (issue_s) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            state_n = MD_BUSY;
                            busy_n  = 1'b1;
                            cnt_n   = MULT_LOAD;
                            res_n   = res_s;
                            dz_n    = 1'b0;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_n = MD_BUSY;
                            busy_n  = 1'b1;
                            cnt_n   = DIV_LOAD;
                            res_n   = res_s;
                            dz_n    = dz_s;
                        end
                        MD_MTHI: hi_n = src_a;
                        MD_MTLO: lo_n = src_a;
                        default: state_n = MD_IDLE;
                    endcase
                end else begin
                    state_n = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_n = MD_IDLE;
                    busy_n  = 1'b0;
                    // A zero divisor burns the full window but leaves HI/LO alone.
                    if (!dz_r) begin
                        hi_n = res_r[63:32];
                        lo_n = res_r[31:0];
                    end else begin
                        hi_n = hi_r;
                        lo_n = lo_r;
                    end
                end else begin
                    cnt_n = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_n = MD_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= MD_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            res_r   <= 64'd0;
            dz_r    <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            busy_r  <= busy_n;
            res_r   <= res_n;
            dz_r    <= dz_n;
            hi_r    <= hi_n;
            lo_r    <= lo_n;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed HI/LO
// results, busy-window lengths and stall behaviour.
module tb_mul_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The pipeline must never present an op while the unit is busy.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && busy === 1'b1 && start === 1'b1) begin
            errors++;
            $error("FAIL start_while_busy: observed start=1 busy=1 expected start=0");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a multi-cycle op and follow it to completion (bounded wait).
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input bit flush_mid,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        #1;
        chk({tag, " stall_issue"}, 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 50) begin
            cycles++;
            flush = flush_mid && (cycles <= 2);
            if (cycles == n) begin
                chk({tag, " hi_before_commit"}, hi, old_hi);
                chk({tag, " lo_before_commit"}, lo, old_lo);
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        chk({tag, " busy_cycles"}, 32'(cycles), 32'(n));
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    // Issue a single-cycle op (mthi/mtlo/none) and check the visible state.
    task automatic one_cycle_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                                input logic fl, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1'b1; md_op = op; src_a = a; src_b = 32'h0000_0000; flush = fl;
        #1;
        chk({tag, " stall"}, 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0; flush = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        @(posedge clk); #1;
        chk({tag, " busy_later"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; md_op = 3'd0;
        src_a = 32'h0; src_b = 32'h0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'h0000_0000);
        chk("reset lo", lo, 32'h0000_0000);
        chk("reset stall_idle", 32'(stall_req), 32'd0);
        start = 1'b1; md_op = 3'd1; #1;
        chk("stall_comb start", 32'(stall_req), 32'd1);
        flush = 1'b1; #1;
        chk("stall_comb flush", 32'(stall_req), 32'd0);
        start = 1'b0; md_op = 3'd0; flush = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult", 3'd1, 32'h0000_0003, 32'hFFFF_FFFE, 5, 1'b0,
               32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 1'b0,
               32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_neg2", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0,
               32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_100_7", 3'd4, 32'h0000_0064, 32'h0000_0007, 10, 1'b0,
               32'h0000_0000, 32'h8000_0000, 32'h0000_0002, 32'h0000_000E);

        one_cycle_op("mthi", 3'd5, 32'h0000_0011, 1'b0, 32'h0000_0011, 32'h0000_000E);
        one_cycle_op("mtlo", 3'd6, 32'h0000_0022, 1'b0, 32'h0000_0011, 32'h0000_0022);

        run_op("divu_by0", 3'd4, 32'h0000_0064, 32'h0000_0000, 10, 1'b0,
               32'h0000_0011, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);

        // start + mult with flush: nothing issues, no stall.
        start = 1'b1; md_op = 3'd1; src_a = 32'h5; src_b = 32'h5; flush = 1'b1;
        #1;
        chk("flush_issue stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0; flush = 1'b0;
        chk("flush_issue busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("flush_issue busy_later", 32'(busy), 32'd0);
        chk("flush_issue hi", hi, 32'h0000_0011);
        chk("flush_issue lo", lo, 32'h0000_0022);

        run_op("mult_flush_mid", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 1'b1,
               32'h0000_0011, 32'h0000_0022, 32'h0000_0001, 32'h0000_0000);

        one_cycle_op("op7_noeffect", 3'd7, 32'hDEAD_BEEF, 1'b0, 32'h0000_0001, 32'h0000_0000);
        one_cycle_op("mtlo_5a5a", 3'd6, 32'h0000_5A5A, 1'b0, 32'h0000_0001, 32'h0000_5A5A);

        // Reset during the third busy cycle of a divide.
        start = 1'b1; md_op = 3'd3; src_a = 32'h0000_0064; src_b = 32'h0000_0003;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        chk("rst_mid busy_before", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid hi", hi, 32'h0000_0000);
        chk("rst_mid lo", lo, 32'h0000_0000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("rst_mid busy_after", 32'(busy), 32'd0);
        chk("rst_mid hi_after", hi, 32'h0000_0000);
        chk("rst_mid lo_after", lo, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
